// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with valid/ready load and internal baud counter.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx #(
    parameter int CLKS_PER_BIT = 2605,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
        DATA_BITS < 5 || DATA_BITS > 8 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_err
        $error("uart_tx: illegal parameter value");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_baud;
    logic [CW-1:0]          w_baud_next;
    logic [2:0]             r_idx;
    logic [2:0]             w_idx_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   w_done;
    logic                   w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
    logic                   w_parity_next;
`endif

    assign w_bit_end = (r_baud == BAUD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_idx    <= w_idx_next;
            r_shift  <= w_shift_next;
            r_tx     <= w_tx_next;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud;
        w_idx_next    = r_idx;
        w_shift_next  = r_shift;
        w_done        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        if (r_state != S_IDLE) begin
            w_baud_next = w_bit_end ? '0 : r_baud + CW'(1);
        end
        unique case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_idx_next  = '0;
                if (tx_start) begin
                    w_shift_next  = tx_data;
`ifdef UART_TX_PARITY_EN
                    w_parity_next = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                    w_state_next  = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_idx_next   = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_idx == LAST_DATA) begin
                        w_idx_next   = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_idx_next   = '0;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // r_idx counts stop bits here; done marks the last cycle of the last one
                if (w_bit_end) begin
                    if (r_idx == LAST_STOP) begin
                        w_done       = 1'b1;
                        w_idx_next   = '0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line level follows the state being entered so tx is a pure flop output
    always_comb begin
        w_tx_next = 1'b1;
        unique case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx_ready = (r_state == S_IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx_done  = w_done & ~rst;
    assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench; a line-level monitor decodes each
// frame and compares it with the expected byte queued when the host was accepted.
module tb_uart_tx;

    localparam int CPB = 16;
    localparam int SMOKE_CPB = 2605;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 1 + 8 + P + 1;
    localparam int FRAME = NB * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready, tx_busy, tx_done, tx;
    logic [7:0] s_data;
    logic       s_start;
    logic       s_ready, s_busy, s_done, s_tx;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
    );

    uart_tx dut_s (
        .clk(clk), .rst(rst), .tx_data(s_data), .tx_start(s_start),
        .tx_ready(s_ready), .tx_busy(s_busy), .tx_done(s_done), .tx(s_tx)
    );

`ifdef UART_TX_PARITY_EN
    logic [7:0] o_data;
    logic       o_start;
    logic       o_ready, o_busy, o_done, o_tx;
    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_o (
        .clk(clk), .rst(rst), .tx_data(o_data), .tx_start(o_start),
        .tx_ready(o_ready), .tx_busy(o_busy), .tx_done(o_done), .tx(o_tx)
    );
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;
    exp_t exp_q[$];

    int frames_ok = 0;
    int aborts = 0;
    int n_sent = 0;
    int last_end = -1000;
    int last_gap = 0;
    bit mon_busy = 1'b0;

    // Reference: expected line level of bit k of a frame carrying d
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (P == 1 && k == 9) return ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
        return 1'b1;
    endfunction

    // Monitor: decode every frame seen on tx and score it
    initial begin
        exp_t       e;
        logic [NB-1:0] bits;
        logic       lvl;
        logic [7:0] rx;
        int bad_lvl, bad_hs, done_pos, done_cnt, s;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || tx !== 1'b0) continue;
            mon_busy = 1'b1;
            s = cyc;
            bad_lvl = 0; bad_hs = 0; done_pos = -1; done_cnt = 0; ab = 1'b0;
            bits = '0; lvl = 1'b0;
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 1, 0);
                e.data = 8'h00;
                e.start = s;
            end else begin
                e = exp_q.pop_front();
            end
            for (int k = 0; k < NB; k++) begin
                if (ab) break;
                for (int c = 0; c < CPB; c++) begin
                    if (!(k == 0 && c == 0)) @(negedge clk);
                    if (rst) begin
                        ab = 1'b1;
                        break;
                    end
                    if (c == 0) lvl = tx;
                    else if (tx !== lvl) bad_lvl++;
                    if (c == CPB / 2) bits[k] = tx;
                    if (tx_ready !== 1'b0 || tx_busy !== 1'b1) bad_hs++;
                    if (tx_done === 1'b1) begin
                        done_cnt++;
                        done_pos = k * CPB + c;
                    end
                end
            end
            if (ab) begin
                aborts++;
            end else begin
                for (int i = 0; i < 8; i++) rx[i] = bits[1+i];
                chk("start_latency", s, e.start);
                chk("start_bit", bits[0], 1'b0);
                chk("data", rx, e.data);
                if (P == 1) chk("parity", bits[NB-2], exp_bit(e.data, NB - 2));
                chk("stop_bit", bits[NB-1], 1'b1);
                chk("bit_steady", bad_lvl, 0);
                chk("ready_busy", bad_hs, 0);
                chk("done_count", done_cnt, 1);
                chk("done_pos", done_pos, FRAME - 1);
                last_gap = s - last_end;
                last_end = s + FRAME - 1;
                frames_ok++;
                @(negedge clk);
                if (!rst) chk("ready_after_done", tx_ready, 1'b1);
            end
            mon_busy = 1'b0;
        end
    end

    task automatic send(input logic [7:0] d, input bit hold);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        tx_data = d;
        tx_start = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            tx_start = 1'b0;
            return;
        end
        exp_q.push_back('{data: d, start: cyc + 1});
        n_sent++;
        @(posedge clk);
        #1;
        if (!hold) tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (tx_ready && !mon_busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int bad, f0, tgt, t_fall, t_rise, acc;
        bit ok;
        logic [7:0] d;
        rst = 1'b1;
        tx_start = 1'b0;
        tx_data = 8'h00;
        s_start = 1'b0;
        s_data = 8'h00;
`ifdef UART_TX_PARITY_EN
        o_start = 1'b0;
        o_data = 8'h00;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || s_tx !== 1'b1) bad++;
        end
        chk("idle_high", bad, 0);

        send(8'hA5, 1'b0);
        wait_idle();

        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        wait_idle();
        chk("b2b_gap", last_gap, 2);

        send(8'h81, 1'b0);
        repeat (3 * CPB) @(posedge clk);
        #1;
        tx_data = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        chk("busy_ready", tx_ready, 1'b0);
        chk("busy_busy", tx_busy, 1'b1);
        @(posedge clk);
        #1 tx_start = 1'b0;
        wait_idle();
        f0 = frames_ok;
        repeat (2 * FRAME) @(negedge clk);
        chk("no_queued_frame", frames_ok, f0);

        send(8'h55, 1'b0);
        tgt = exp_q[0].start + 5 * CPB + 3;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk);
            if (cyc >= tgt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rst_mid_timeout", 0, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_done", tx_done, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_ready", tx_ready, 1'b1);
        chk("rst_mid_nodone", tx_done, 1'b0);
        chk("rst_mid_abort", aborts, 1);
        send(8'h0F, 1'b0);
        wait_idle();

        send(8'h07, 1'b0);
        wait_idle();

        repeat (8) begin
            d = 8'($urandom);
            send(d, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, FRAME - 6)) @(posedge clk);
                #1;
                tx_data = 8'($urandom);
                tx_start = 1'b1;
                @(posedge clk);
                #1 tx_start = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end

`ifdef UART_TX_PARITY_EN
        @(posedge clk);
        #1;
        o_data = 8'h07;
        o_start = 1'b1;
        @(negedge clk);
        acc = cyc + 1;
        @(posedge clk);
        #1 o_start = 1'b0;
        while (cyc < acc + 9 * CPB + CPB / 2) @(negedge clk);
        chk("odd_parity", o_tx, 1'b0);
        while (cyc < acc + FRAME - 2) @(negedge clk);
        chk("odd_done_early", o_done, 1'b0);
        @(negedge clk);
        chk("odd_done", o_done, 1'b1);
`endif

        @(posedge clk);
        #1;
        s_data = 8'hC3;
        s_start = 1'b1;
        @(negedge clk);
        acc = cyc + 1;
        @(posedge clk);
        #1 s_start = 1'b0;
        t_fall = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_tx === 1'b0) begin
                t_fall = cyc;
                break;
            end
        end
        chk("smoke_fall", t_fall, acc);
        t_rise = -1;
        for (int i = 0; i < 2 * SMOKE_CPB; i++) begin
            @(negedge clk);
            if (s_tx === 1'b1) begin
                t_rise = cyc;
                break;
            end
        end
        chk("smoke_start_width", t_rise - t_fall, SMOKE_CPB);
        tgt = -1;
        for (int i = 0; i < 3 * SMOKE_CPB; i++) begin
            @(negedge clk);
            if (s_tx === 1'b0) begin
                tgt = cyc;
                break;
            end
        end
        chk("smoke_high_width", tgt - t_rise, 2 * SMOKE_CPB);
        tgt = -1;
        for (int i = 0; i < NB * SMOKE_CPB; i++) begin
            @(negedge clk);
            if (s_done === 1'b1) begin
                tgt = cyc;
                break;
            end
        end
        chk("smoke_done", tgt - t_fall, NB * SMOKE_CPB - 1);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("frames_total", frames_ok, n_sent - 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. It is the transmit-side counterpart of the team's UART receiver.
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- A host loads a byte with a valid/ready handshake. The block drives the `tx` line, idling high, and pulses `tx_done` when the frame completes.
- Bit timing comes from an internal baud counter, so no external tick is required.

Parameters:
- CLKS_PER_BIT, 2605, clk cycles per serial bit. Legal values are 2 to 65535.
- DATA_BITS, 8, data bits per frame. Legal values are 5 to 8.
- STOP_BITS, 1, number of stop bits. Legal values are 1 or 2.
- PARITY_ODD, 0, parity sense. 0 = even, 1 = odd. Only used when UART_TX_PARITY_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- tx_data  in  DATA_BITS  byte to send. Sampled only on an accept cycle.
- tx_start  in  1  request to send. Accepted when `tx_start` && `tx_ready`.
- tx_ready  out  1  high while in IDLE (new request can be accepted).
- tx_busy  out  1  high from the cycle after accept until the frame ends (inverse of `tx_ready`).
- tx_done  out  1  single-cycle pulse on the final cycle of the last stop bit.
- tx  out  1  serial line, registered output.

Behaviour:
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0. State=IDLE, baud counter=0, bit index=0, shift register=0.
- Reset mid-frame: on the next edge `tx` returns to 1 and state goes to IDLE. No `tx_done` pulse is issued.
- FSM states and transitions:
  - IDLE: `tx`=1. On accept, latch `tx_data` into the shift register, clear the baud counter, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit DATA_BITS-1, go to PARITY if enabled, else STOP.
  - PARITY (macro only): `tx`=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `tx`=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - The bit boundary is the cycle the count equals CLKS_PER_BIT-1; the counter wraps to 0 there.
  - Counter width is clog2(CLKS_PER_BIT).
  - The counter is held at 0 in IDLE.
- Latency and timing:
  - `tx` falls on the clk edge following the accept cycle.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Frame length is (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P = 1 with parity, else 0.
- `tx_done`: asserted during the last cycle of the final stop bit. `tx_ready` rises on the next cycle, together with the return to IDLE.
- Back-to-back frames:
  - `tx_start` held high is accepted in the first IDLE cycle.
  - That IDLE cycle drives `tx`=1, so there is a minimum of one extra idle-high cycle between frames.
  - The next start bit begins on the following edge.
- `tx_start` while busy: ignored, with no queueing. `tx_data` changes while busy have no effect.
- `tx` is glitch-free: it is driven directly from a flop, never from combinational decode.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - The PARITY state is inserted after the last data bit.
  - Parity bit = XOR of the latched data bits, XOR PARITY_ODD. The total count of ones over data+parity is even for PARITY_ODD=0 and odd for PARITY_ODD=1.
  - Parity is computed from the latched copy at accept time.
- When undefined:
  - No PARITY state and no parity logic.
  - The frame goes directly from DATA to STOP.
  - PARITY_ODD is ignored.

Test Plan:
- Reset: assert `rst` 3 cycles, release → `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0. Hold idle 100 cycles → `tx` stays 1.
- Single frame: CLKS_PER_BIT=16, send 8'hA5 → `tx` waveform 0,1,0,1,0,0,1,0,1,1, each level 16 cycles. `tx_done` pulses once at cycle 160 after accept. Bench UART model decodes 8'hA5.
- Back-to-back: CLKS_PER_BIT=16, hold `tx_start`=1 with 8'h00 then 8'hFF → two frames separated by exactly one idle-high cycle. Decoded 8'h00, 8'hFF. Two `tx_done` pulses.
- Busy ignore: pulse `tx_start` with 8'h3C mid-frame of 8'h81 → only 8'h81 transmitted, `tx_ready` stays 0 until frame end, no second frame.
- Reset mid-frame: assert `rst` during data bit 4 of 8'h55 → `tx`=1 on next edge, no `tx_done`. A new request 8'h0F after reset transmits correctly.
- Parity (UART_TX_PARITY_EN, CLKS_PER_BIT=16): 8'h07 with PARITY_ODD=0 → parity bit 1, frame 11 bits/176 cycles. With PARITY_ODD=1 → parity bit 0. Default CLKS_PER_BIT=2605 smoke run on 8'hC3 → bit width measured as 2605 cycles.
